hdmi_timing_ctrl: RTL and testbench

- Programmable video timing sequencer for the HDMI output path. Generates hs/vs/de and pixel coordinates that drive the pattern/pixel datapath feeding the ADV7511.
- Timing is configured through an ENA/RDY method. New timing is applied only at a frame boundary.
- Emits a per-frame indication toward software; sits between the Echo-style request/indication wrapper and the HDMI block.

---
 rtl/hdmi_timing_pkg.sv | 34 +++
 rtl/hdmi_timing_axis.sv | 41 ++++
 rtl/hdmi_timing_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hdmi_timing_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI video timing sequencer.
// The 1080p60 defaults live here so top-level parameters and the bench agree.
package hdmi_timing_pkg;

    localparam int CW = 12;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    typedef struct packed {
        logic [CW-1:0] act;
        logic [CW-1:0] fp;
        logic [CW-1:0] sync;
        logic [CW-1:0] bp;
    } timing_axis_t;

    localparam int H_ACT_1080 = 1920;
    localparam int H_FP_1080  = 88;
    localparam int H_SYNC_1080 = 44;
    localparam int H_BP_1080  = 148;
    localparam int V_ACT_1080 = 1080;
    localparam int V_FP_1080  = 4;
    localparam int V_SYNC_1080 = 5;
    localparam int V_BP_1080  = 36;

    // Two guard bits so four max-size fields never overflow.
    function automatic logic [CW+1:0] total(input timing_axis_t t);
        return {2'b00, t.act} + {2'b00, t.fp} + {2'b00, t.sync} + {2'b00, t.bp};
    endfunction

    function automatic logic timing_ok(input timing_axis_t t);
        return (t.act != '0) && (t.sync != '0);
    endfunction

endpackage

// File: rtl/hdmi_timing_axis.sv
// One timing axis (horizontal or vertical): wrapping counter plus region decode.
module hdmi_timing_axis
    import hdmi_timing_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_clr,
    input  logic          i_adv,
    input  timing_axis_t  i_t,
    output logic [CW-1:0] o_cnt,
    output logic          o_active,
    output logic          o_sync,
    output logic          o_last
);

    localparam logic [CW+1:0] ONE = (CW+2)'(1);

    logic [CW-1:0] r_cnt;
    logic [CW+1:0] w_cnt;
    logic [CW+1:0] w_sync_lo;
    logic [CW+1:0] w_sync_hi;

    assign w_cnt     = {2'b00, r_cnt};
    assign w_sync_lo = {2'b00, i_t.act} + {2'b00, i_t.fp};
    assign w_sync_hi = w_sync_lo + {2'b00, i_t.sync};

    assign o_cnt    = r_cnt;
    assign o_last   = (w_cnt == total(i_t) - ONE);
    assign o_active = (w_cnt < {2'b00, i_t.act});
    assign o_sync   = (w_cnt >= w_sync_lo) && (w_cnt < w_sync_hi);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_adv)
            r_cnt <= o_last ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Programmable hs/vs/de sequencer with frame-boundary timing updates.
// Optional macro HDMI_TIMING_POLARITY_EN adds setTiming_pol = {hpol,vpol}.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACT  = H_ACT_1080,
    parameter int H_FP   = H_FP_1080,
    parameter int H_SYNC = H_SYNC_1080,
    parameter int H_BP   = H_BP_1080,
    parameter int V_ACT  = V_ACT_1080,
    parameter int V_FP   = V_FP_1080,
    parameter int V_SYNC = V_SYNC_1080,
    parameter int V_BP   = V_BP_1080
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            setTiming__ENA,
    input  logic [4*CW-1:0] setTiming_h,
    input  logic [4*CW-1:0] setTiming_v,
`ifdef HDMI_TIMING_POLARITY_EN
    input  logic [1:0]      setTiming_pol,
`endif
    output logic            setTiming__RDY,
    input  logic            run__ENA,
    input  logic            run_v,
    output logic            run__RDY,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic [CW-1:0]   pixelX,
    output logic [CW-1:0]   pixelY,
    output logic            frameStart__ENA,
    input  logic            frameStart__RDY,
    output logic [7:0]      missed,
    output logic            cfgErr
);

    localparam timing_axis_t H_DEF = '{act: CW'(H_ACT), fp: CW'(H_FP), sync: CW'(H_SYNC), bp: CW'(H_BP)};
    localparam timing_axis_t V_DEF = '{act: CW'(V_ACT), fp: CW'(V_FP), sync: CW'(V_SYNC), bp: CW'(V_BP)};

    state_t         r_state, w_next;
    timing_axis_t   r_h, r_v, r_sh_h, r_sh_v;
    logic           r_pend, r_err;
    logic           r_hs, r_vs, r_de, r_fs;
    logic [CW-1:0]  r_px, r_py;
    logic [7:0]     r_missed;
    logic [1:0]     w_pol;

    logic           w_run, w_frame_end, w_accept, w_ok, w_apply;
    logic [CW-1:0]  w_hc, w_vc;
    logic           w_h_act, w_h_sync, w_h_last;
    logic           w_v_act, w_v_sync, w_v_last;
    timing_axis_t   w_new_h, w_new_v;

    assign w_new_h     = timing_axis_t'(setTiming_h);
    assign w_new_v     = timing_axis_t'(setTiming_v);
    assign w_run       = (r_state != IDLE);
    assign w_frame_end = w_run && w_h_last && w_v_last;
    assign w_accept    = setTiming__ENA && !r_pend;
    assign w_ok        = timing_ok(w_new_h) && timing_ok(w_new_v);
    // Pending is registered, so a request accepted on a frame-end cycle waits a frame.
    assign w_apply     = r_pend && (w_frame_end || (r_state == IDLE));

    hdmi_timing_axis u_h (
        .CLK(CLK), .RST(RST), .i_clr(!w_run), .i_adv(w_run), .i_t(r_h),
        .o_cnt(w_hc), .o_active(w_h_act), .o_sync(w_h_sync), .o_last(w_h_last)
    );

    hdmi_timing_axis u_v (
        .CLK(CLK), .RST(RST), .i_clr(!w_run), .i_adv(w_run && w_h_last), .i_t(r_v),
        .o_cnt(w_vc), .o_active(w_v_act), .o_sync(w_v_sync), .o_last(w_v_last)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (run__ENA && run_v) w_next = RUN;
            RUN:     if (run__ENA && !run_v) w_next = STOP;
            STOP:    if (run__ENA && run_v) w_next = RUN;
                     else if (w_frame_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_h     <= H_DEF;
            r_v     <= V_DEF;
            r_sh_h  <= H_DEF;
            r_sh_v  <= V_DEF;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_apply) begin
                r_h    <= r_sh_h;
                r_v    <= r_sh_v;
                r_pend <= 1'b0;
            end else if (w_accept && w_ok) begin
                r_sh_h <= w_new_h;
                r_sh_v <= w_new_v;
                r_pend <= 1'b1;
            end
            if (w_accept && !w_ok)
                r_err <= 1'b1;
        end
    end

`ifdef HDMI_TIMING_POLARITY_EN
    logic [1:0] r_pol, r_sh_pol;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pol    <= 2'b00;
            r_sh_pol <= 2'b00;
        end else if (w_apply) begin
            r_pol <= r_sh_pol;
        end else if (w_accept && w_ok) begin
            r_sh_pol <= setTiming_pol;
        end
    end
    assign w_pol = r_pol;
`else
    assign w_pol = 2'b00;
`endif

    // Decode is registered: every output lags the counters by one clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_de     <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
            r_fs     <= 1'b0;
            r_missed <= 8'd0;
        end else begin
            r_hs <= (w_run && w_h_sync) ^ w_pol[1];
            r_vs <= (w_run && w_v_sync) ^ w_pol[0];
            r_de <= w_run && w_h_act && w_v_act;
            r_px <= (w_run && w_h_act && w_v_act) ? w_hc : '0;
            r_py <= (w_run && w_h_act && w_v_act) ? w_vc : '0;
            r_fs <= w_run && (w_hc == '0) && (w_vc == '0);
            if (r_fs && !frameStart__RDY && (r_missed != 8'hFF))
                r_missed <= r_missed + 8'd1;
        end
    end

    assign setTiming__RDY  = !r_pend;
    assign run__RDY        = 1'b1;
    assign hs              = r_hs;
    assign vs              = r_vs;
    assign de              = r_de;
    assign pixelX          = r_px;
    assign pixelY          = r_py;
    assign frameStart__ENA = r_fs && frameStart__RDY;
    assign missed          = r_missed;
    assign cfgErr          = r_err;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench for hdmi_timing_ctrl on a tiny 8x6 timing (48-clock frames).
`timescale 1ns/1ps
module tb_hdmi_timing_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        st_ena = 1'b0;
    logic [47:0] st_h = '0, st_v = '0;
    logic        st_rdy, run_ena = 1'b0, run_v = 1'b0, run_rdy;
    logic        hs, vs, de, fs_ena, fs_rdy = 1'b1, cfg_err;
    logic [11:0] px, py;
    logic [7:0]  missed;

    int total = 0, bad = 0;

    // Hand-derived masks for h={4,1,2,1}, v={3,1,1,1}.
    logic [7:0] de_h = 8'b0000_1111;
    logic [7:0] hs_h = 8'b0110_0000;
    logic [5:0] de_v = 6'b00_0111;
    logic [5:0] vs_v = 6'b01_0000;

    hdmi_timing_ctrl #(
        .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .setTiming__ENA(st_ena), .setTiming_h(st_h), .setTiming_v(st_v),
        .setTiming__RDY(st_rdy),
        .run__ENA(run_ena), .run_v(run_v), .run__RDY(run_rdy),
        .hs(hs), .vs(vs), .de(de), .pixelX(px), .pixelY(py),
        .frameStart__ENA(fs_ena), .frameStart__RDY(fs_rdy),
        .missed(missed), .cfgErr(cfg_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [47:0] pk(input int a, input int f, input int s, input int b);
        return {12'(a), 12'(f), 12'(s), 12'(b)};
    endfunction

    // Output sample k of a default-timing frame shows counters hc=k%8, vc=k/8.
    task automatic chk_cycles(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            int hc, vc;
            logic de_e;
            tick();
            st_ena  = 1'b0;
            run_ena = 1'b0;
            hc = k % 8;
            vc = k / 8;
            de_e = de_h[hc] & de_v[vc];
            chk($sformatf("de k%0d", k), 32'(de), 32'(de_e));
            chk($sformatf("hs k%0d", k), 32'(hs), 32'(hs_h[hc]));
            chk($sformatf("vs k%0d", k), 32'(vs), 32'(vs_v[vc]));
            chk($sformatf("px k%0d", k), 32'(px), de_e ? 32'(hc) : 32'd0);
            chk($sformatf("py k%0d", k), 32'(py), de_e ? 32'(vc) : 32'd0);
            chk($sformatf("fs k%0d", k), 32'(fs_ena), 32'(k == 0));
        end
    endtask

    initial begin
        int cnt_de, cnt_fs;
        // Reset state
        tick();
        chk("rst_de", 32'(de), 0);
        chk("rst_hs", 32'(hs), 0);
        chk("rst_vs", 32'(vs), 0);
        chk("rst_fs", 32'(fs_ena), 0);
        chk("rst_strdy", 32'(st_rdy), 1);
        chk("rst_runrdy", 32'(run_rdy), 1);
        chk("rst_missed", 32'(missed), 0);
        chk("rst_cfgerr", 32'(cfg_err), 0);
        RST = 1'b0;
        tick();
        chk("idle_de", 32'(de), 0);

        // Start and check two back-to-back frames
        run_ena = 1'b1; run_v = 1'b1;
        tick();
        chk_cycles(0, 47);
        chk_cycles(0, 47);

        // Dropped frameStart pulses, then saturation
        fs_rdy = 1'b0;
        tick();
        chk("fs_dropped", 32'(fs_ena), 0);
        repeat (143) tick();
        chk("missed3", 32'(missed), 3);
        repeat (300 * 48) tick();
        chk("missed_sat", 32'(missed), 255);
        fs_rdy = 1'b1;
        chk_cycles(0, 47);

        // Mid-frame setTiming: h={2,1,1,1} takes effect at frame end
        chk_cycles(0, 9);
        st_h = pk(2, 1, 1, 1); st_v = pk(3, 1, 1, 1); st_ena = 1'b1;
        chk_cycles(10, 10);
        chk("st_pend", 32'(st_rdy), 0);
        chk_cycles(11, 46);
        chk("st_pend_end", 32'(st_rdy), 0);
        chk_cycles(47, 47);
        chk("st_applied", 32'(st_rdy), 1);
        tick();
        chk("n0_fs", 32'(fs_ena), 1);
        chk("n0_de", 32'(de), 1);
        tick();
        chk("n1_de", 32'(de), 1);
        chk("n1_px", 32'(px), 1);
        tick();
        chk("n2_de", 32'(de), 0);
        tick();
        chk("n3_hs", 32'(hs), 1);
        tick();
        chk("n4_hs", 32'(hs), 0);
        tick();
        chk("n5_de", 32'(de), 1);
        chk("n5_px", 32'(px), 0);
        chk("n5_py", 32'(py), 1);
        repeat (24) tick();
        // Restore the 8-clock line for the remaining tests
        st_h = pk(4, 1, 2, 1); st_ena = 1'b1;
        tick();
        st_ena = 1'b0;
        chk("rest_pend", 32'(st_rdy), 0);
        repeat (29) tick();
        chk("rest_applied", 32'(st_rdy), 1);

        // Stop at clock 10: frame completes, then idle
        chk_cycles(0, 9);
        run_ena = 1'b1; run_v = 1'b0;
        chk_cycles(10, 47);
        tick();
        chk("stop_de", 32'(de), 0);
        chk("stop_hs", 32'(hs), 0);
        chk("stop_vs", 32'(vs), 0);
        cnt_de = 0; cnt_fs = 0;
        repeat (48) begin
            tick();
            cnt_de += 32'(de);
            cnt_fs += 32'(fs_ena);
        end
        chk("idle_de_cnt", 32'(cnt_de), 0);
        chk("idle_fs_cnt", 32'(cnt_fs), 0);

        // Restart; stop then resume inside the frame, no gap
        run_ena = 1'b1; run_v = 1'b1;
        tick();
        chk_cycles(0, 19);
        run_ena = 1'b1; run_v = 1'b0;
        chk_cycles(20, 29);
        run_ena = 1'b1; run_v = 1'b1;
        chk_cycles(30, 47);
        chk_cycles(0, 47);

        // Async reset mid-line with a pending update
        chk_cycles(0, 4);
        st_h = pk(2, 1, 1, 1); st_v = pk(3, 1, 1, 1); st_ena = 1'b1;
        chk_cycles(5, 6);
        chk("pre_rst_pend", 32'(st_rdy), 0);
        #2 RST = 1'b1;
        #1;
        chk("arst_hs", 32'(hs), 0);
        chk("arst_de", 32'(de), 0);
        chk("arst_fs", 32'(fs_ena), 0);
        chk("arst_strdy", 32'(st_rdy), 1);
        chk("arst_missed", 32'(missed), 0);
        tick();
        RST = 1'b0;
        run_ena = 1'b1; run_v = 1'b1;
        tick();
        chk_cycles(0, 47);

        // Rejected update: v.act = 0
        chk("pre_cfgerr", 32'(cfg_err), 0);
        st_h = pk(4, 1, 2, 1); st_v = pk(0, 1, 1, 1); st_ena = 1'b1;
        chk_cycles(0, 0);
        chk("cfgerr_set", 32'(cfg_err), 1);
        chk("cfgerr_rdy", 32'(st_rdy), 1);
        chk_cycles(1, 47);
        chk_cycles(0, 47);
        chk("cfgerr_sticky", 32'(cfg_err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
